// File: rtl/nabp_ramp_filter_pkg.sv
// Shared constants, state encoding and coefficient generator for the ramp (Ram-Lak) FIR stage.
package nabp_ramp_filter_pkg;

  localparam int unsigned kFilteredDataLength = 16;
  localparam int unsigned kSLength            = 8;
  localparam int unsigned kDataW              = 8;
  localparam int unsigned kNumTaps            = 7;
  localparam int unsigned kCoefW              = 12;
  localparam int unsigned kCoefFrac           = 10;

  localparam real kPi = 3.14159265358979;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFlush,
    StDrain
  } ramp_state_e;

  // Ram-Lak tap n quantised to frac bits: 0.25 at n=0, 0 for even n, -1/(n^2 pi^2) for odd n.
  function automatic int ramp_coef(int n, int frac);
    real r;
    int  m;
    m = (n < 0) ? -n : n;
    if (m == 0) return 1 << (frac - 2);
    if ((m % 2) == 0) return 0;
    r = (2.0 ** frac) / (kPi * kPi * real'(m * m));
    return -$rtoi(r + 0.5);
  endfunction

endpackage

// File: rtl/nabp_fir_mac_pipe.sv
// Three-stage multiply / pairwise-add / round-and-saturate pipeline for the ramp filter.
module nabp_fir_mac_pipe
  import nabp_ramp_filter_pkg::*;
#(
  parameter int unsigned DATA_W    = kDataW,
  parameter int unsigned OUT_W     = kFilteredDataLength,
  parameter int unsigned NUM_TAPS  = kNumTaps,
  parameter int unsigned COEF_W    = kCoefW,
  parameter int unsigned COEF_FRAC = kCoefFrac
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         shift_en_i,
  input  logic                         valid_i,
  input  logic                         last_i,
  input  logic [NUM_TAPS*DATA_W-1:0]   window_i,
  output logic [OUT_W-1:0]             out_val_o,
  output logic                         out_valid_o,
  output logic                         out_last_o
);

  localparam int unsigned H         = (NUM_TAPS - 1) / 2;
  localparam int unsigned PROD_W    = COEF_W + DATA_W + 1;
  localparam int unsigned NUM_PAIRS = (NUM_TAPS + 1) / 2;
  localparam int unsigned SUM_W     = PROD_W + $clog2(NUM_TAPS) + 1;

  localparam logic signed [SUM_W-1:0] kMax = {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] kMin = {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [SUM_W-1:0]  pair_d [NUM_PAIRS];
  logic signed [SUM_W-1:0]  pair_q [NUM_PAIRS];
  logic signed [SUM_W-1:0]  total, rounded, scaled;
  logic        [OUT_W-1:0]  sat_d, out_val_q;
  logic                     s1_valid_q, s2_valid_q, out_valid_q;
  logic                     s1_last_q, s2_last_q, out_last_q;

  // Window slot i holds x[k+H-i], so its coefficient is h[H-i].
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    localparam logic signed [COEF_W-1:0] Coef = COEF_W'(ramp_coef(int'(H) - i, COEF_FRAC));
    logic signed [DATA_W:0] x_ext;
    assign x_ext     = {1'b0, window_i[i*DATA_W +: DATA_W]};
    assign prod_d[i] = PROD_W'(Coef) * PROD_W'(x_ext);
  end

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    if (2 * p + 1 < NUM_TAPS) begin : g_two
      assign pair_d[p] = SUM_W'(prod_q[2*p]) + SUM_W'(prod_q[2*p+1]);
    end else begin : g_one
      assign pair_d[p] = SUM_W'(prod_q[2*p]);
    end
  end

  always_comb begin
    total = '0;
    for (int p = 0; p < NUM_PAIRS; p++) total = total + pair_q[p];
    rounded = total + SUM_W'(1 << (COEF_FRAC - 1));
    scaled  = rounded >>> COEF_FRAC;
    if (scaled > kMax) begin
      sat_d = kMax[OUT_W-1:0];
    end else if (scaled < kMin) begin
      sat_d = kMin[OUT_W-1:0];
    end else begin
      sat_d = scaled[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= '0;
      for (int p = 0; p < NUM_PAIRS; p++) pair_q[p] <= '0;
      out_val_q   <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (shift_en_i) begin
        for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= prod_d[i];
      end
      if (s1_valid_q) begin
        for (int p = 0; p < NUM_PAIRS; p++) pair_q[p] <= pair_d[p];
      end
      if (s2_valid_q) out_val_q <= sat_d;
      s1_valid_q  <= shift_en_i & valid_i;
      s1_last_q   <= shift_en_i & valid_i & last_i;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_last_q;
    end
  end

  assign out_val_o   = out_val_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

endmodule

// File: rtl/nabp_ramp_filter.sv
// Streaming ramp FIR stage: line FSM, zero padding and delay line in front of the MAC pipeline.
module nabp_ramp_filter
  import nabp_ramp_filter_pkg::*;
#(
  parameter int unsigned DATA_W    = kDataW,
  parameter int unsigned OUT_W     = kFilteredDataLength,
  parameter int unsigned S_W       = kSLength,
  parameter int unsigned NUM_TAPS  = kNumTaps,
  parameter int unsigned COEF_W    = kCoefW,
  parameter int unsigned COEF_FRAC = kCoefFrac
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [S_W-1:0]    line_len_i,
  input  logic [DATA_W-1:0] in_val_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [OUT_W-1:0]  out_val_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int unsigned H    = (NUM_TAPS - 1) / 2;
  localparam int unsigned PadW = $clog2(H + 1);

  ramp_state_e                state_q, state_d;
  logic [S_W-1:0]             len_q, len_d;
  logic [S_W-1:0]             in_cnt_q, in_cnt_d;
  logic [PadW-1:0]            pad_cnt_q, pad_cnt_d;
  logic [PadW-1:0]            warm_q, warm_d;
  logic [NUM_TAPS*DATA_W-1:0] win_q, win_d;
  logic [DATA_W-1:0]          shift_data;
  logic                       shift, clear_win, in_ready, tag_last, tag_valid;
  logic                       pipe_last;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    warm_d     = warm_q;
    shift      = 1'b0;
    shift_data = '0;
    in_ready   = 1'b0;
    tag_last   = 1'b0;
    clear_win  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && (line_len_i != '0)) begin
          len_d     = line_len_i;
          in_cnt_d  = '0;
          pad_cnt_d = '0;
          warm_d    = '0;
          clear_win = 1'b1;
          state_d   = StFill;
        end
      end
      StFill: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          shift      = 1'b1;
          shift_data = in_val_i;
          in_cnt_d   = in_cnt_q + S_W'(1);
          if (in_cnt_q == len_q - S_W'(1)) state_d = StFlush;
        end
      end
      StFlush: begin
        // Right padding: zeros are shifted in unconditionally.
        shift     = 1'b1;
        pad_cnt_d = pad_cnt_q + PadW'(1);
        if (pad_cnt_q == PadW'(H - 1)) begin
          tag_last = 1'b1;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (pipe_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // The first H shifts only prime the window; every later shift yields one output.
    if (shift && (warm_q != PadW'(H))) warm_d = warm_q + PadW'(1);
  end

  assign tag_valid = shift && (warm_q == PadW'(H));
  assign win_d     = {win_q[(NUM_TAPS-1)*DATA_W-1:0], shift_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      in_cnt_q  <= '0;
      pad_cnt_q <= '0;
      warm_q    <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      warm_q    <= warm_d;
      if (clear_win) begin
        win_q <= '0;
      end else if (shift) begin
        win_q <= win_d;
      end
    end
  end

  nabp_fir_mac_pipe #(
    .DATA_W   (DATA_W),
    .OUT_W    (OUT_W),
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .COEF_FRAC(COEF_FRAC)
  ) u_mac_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en_i (shift),
    .valid_i    (tag_valid),
    .last_i     (tag_last),
    .window_i   (win_d),
    .out_val_o  (out_val_o),
    .out_valid_o(out_valid_o),
    .out_last_o (pipe_last)
  );

  assign out_last_o = pipe_last;
  assign in_ready_o = in_ready;
  assign busy_o     = (state_q != StIdle);

endmodule
